baby_vga_pixel: RTL and testbench

- Pixel stage directly downstream of the VGA timing generator in the baby_vga peripheral.
- Consumes the split beam counters (x_hi/x_lo, y_hi/y_lo) and the hsync/vsync/blank signals.
- Renders a 32x16-cell, 1-bit-per-cell framebuffer (20x30-pixel cells) as RGB222, using foreground/background colour registers.
- Outputs RGB and syncs mutually aligned; host writes via a simple register port.

---
 rtl/baby_vga_pkg.sv | 46 ++++
 rtl/baby_vga_fb_bank.sv | 41 ++++
 rtl/baby_vga_pixel.sv | 180 ++++++++++++++++++
 tb/tb_baby_vga_pixel.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/baby_vga_pkg.sv
// Shared constants, types and write-address decoding for the baby_vga pixel stage.
package baby_vga_pkg;

  localparam int COLS   = 32;
  localparam int ROWS   = 16;
  localparam int X_HI_W = 6;
  localparam int X_LO_W = 5;
  localparam int Y_HI_W = 5;
  localparam int Y_LO_W = 6;
  localparam int RGB_W  = 6;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ADDR_FG = 5'd16;
  localparam logic [ADDR_W-1:0] ADDR_BG = 5'd17;

  typedef enum logic [1:0] {
    WR_ROW  = 2'd0,
    WR_FG   = 2'd1,
    WR_BG   = 2'd2,
    WR_NONE = 2'd3
  } wr_kind_e;

  // Pixel-lookup stage payload: framebuffer bit plus the blank that travels with it.
  typedef struct packed {
    logic pix;
    logic blank;
  } stage_a_t;

  // Addresses 0..15 are rows, 16/17 colours, everything above is a silent no-op.
  function automatic wr_kind_e decode_wr(input logic [ADDR_W-1:0] addr);
    wr_kind_e kind;
    if (addr < ADDR_W'(ROWS)) begin
      kind = WR_ROW;
    end else if (addr == ADDR_FG) begin
      kind = WR_FG;
    end else if (addr == ADDR_BG) begin
      kind = WR_BG;
    end else begin
      kind = WR_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/baby_vga_fb_bank.sv
// One 16x32 bit framebuffer bank: full-row synchronous write, combinational bit read.
module baby_vga_fb_bank
  import baby_vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic             rd_bit
);

  logic [COLS-1:0] rows_q [ROWS];
  logic [COLS-1:0] rows_d [ROWS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      rows_d[r] = rows_q[r];
    end
    if (wr_en) begin
      rows_d[wr_row] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        rows_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        rows_q[r] <= rows_d[r];
      end
    end
  end

  assign rd_bit = rows_q[rd_row][rd_col];

endmodule

// File: rtl/baby_vga_pixel.sv
// baby_vga pixel stage: two-cycle beam-to-RGB pipeline with colour registers.
// Optional double buffering with vsync-aligned swap: BABY_VGA_DOUBLE_BUFFER_EN.
module baby_vga_pixel
  import baby_vga_pkg::*;
#(
  parameter logic [RGB_W-1:0] FG_RESET = 6'h3F,
  parameter logic [RGB_W-1:0] BG_RESET = 6'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [X_HI_W-1:0] x_hi,
  input  logic [X_LO_W-1:0] x_lo,
  input  logic [Y_HI_W-1:0] y_hi,
  input  logic [Y_LO_W-1:0] y_lo,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COLS-1:0]   wr_data,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              frame_start,
  output logic [RGB_W-1:0]  rgb,
  output logic              hsync_out,
  output logic              vsync_out
);

  // Host port: wr_en is a valid with an implied ready of 1; every strobed cycle is consumed.
  wr_kind_e wr_kind;
  logic     row_wr_en;
  assign wr_kind   = decode_wr(wr_addr);
  assign row_wr_en = wr_en && (wr_kind == WR_ROW);

  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic             front_bit;
  assign rd_row = y_hi[ROW_W-1:0];
  assign rd_col = x_hi[COL_W-1:0];

  // Sub-cell position and the out-of-range index bits never affect the image.
  logic unused_beam_bits;
  assign unused_beam_bits = ^{x_lo, y_lo, x_hi[X_HI_W-1:COL_W], y_hi[Y_HI_W-1:ROW_W]};

  logic [RGB_W-1:0] fg_q, fg_d;
  logic [RGB_W-1:0] bg_q, bg_d;
  stage_a_t         stage_a_q, stage_a_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vsync_prev_q, vsync_prev_d;
  logic             frame_start_q, frame_start_d;
  logic             vsync_rise;

  assign vsync_rise = vsync_in && !vsync_prev_q;

`ifdef BABY_VGA_DOUBLE_BUFFER_EN
  logic       bank_sel_q, bank_sel_d;
  logic       swap_pending_q, swap_pending_d;
  logic [1:0] bank_bit;
  logic [1:0] bank_wr;

  // Rows always land in the bank not on screen; on a swap cycle that is the pre-swap back bank.
  assign bank_wr[0] = row_wr_en && bank_sel_q;
  assign bank_wr[1] = row_wr_en && !bank_sel_q;

  baby_vga_fb_bank u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_wr[0]),
    .wr_row  (wr_addr[ROW_W-1:0]),
    .wr_data (wr_data),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_bit  (bank_bit[0])
  );

  baby_vga_fb_bank u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_wr[1]),
    .wr_row  (wr_addr[ROW_W-1:0]),
    .wr_data (wr_data),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_bit  (bank_bit[1])
  );

  assign front_bit = bank_sel_q ? bank_bit[1] : bank_bit[0];

  // A request raised on the edge cycle itself waits for the next frame.
  always_comb begin
    bank_sel_d     = bank_sel_q;
    swap_pending_d = swap_pending_q;
    if (vsync_rise && swap_pending_q) begin
      bank_sel_d     = !bank_sel_q;
      swap_pending_d = 1'b0;
    end else if (swap_req) begin
      swap_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel_q     <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      bank_sel_q     <= bank_sel_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign swap_pending = swap_pending_q;
`else
  baby_vga_fb_bank u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (row_wr_en),
    .wr_row  (wr_addr[ROW_W-1:0]),
    .wr_data (wr_data),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_bit  (front_bit)
  );

  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign swap_pending    = 1'b0;
`endif

  always_comb begin
    fg_d = fg_q;
    bg_d = bg_q;
    if (wr_en && (wr_kind == WR_FG)) begin
      fg_d = wr_data[RGB_W-1:0];
    end
    if (wr_en && (wr_kind == WR_BG)) begin
      bg_d = wr_data[RGB_W-1:0];
    end
  end

  // Syncs arrive one cycle late, so a single register re-aligns them with rgb.
  always_comb begin
    stage_a_d.pix   = front_bit;
    stage_a_d.blank = blank_in;
    rgb_d           = stage_a_q.blank ? '0 : (stage_a_q.pix ? fg_q : bg_q);
    hsync_d         = hsync_in;
    vsync_d         = vsync_in;
    vsync_prev_d    = vsync_in;
    frame_start_d   = vsync_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fg_q          <= FG_RESET;
      bg_q          <= BG_RESET;
      stage_a_q     <= '{pix: 1'b0, blank: 1'b1};
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b0;
      vsync_prev_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      fg_q          <= fg_d;
      bg_q          <= bg_d;
      stage_a_q     <= stage_a_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vsync_prev_q  <= vsync_prev_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_baby_vga_pixel.sv
// Scoreboard bench for baby_vga_pixel; covers both the single- and double-buffer builds.
module tb_baby_vga_pixel;

`ifdef BABY_VGA_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  x_hi;
  logic [4:0]  x_lo;
  logic [4:0]  y_hi;
  logic [5:0]  y_lo;
  logic        hsync_in, vsync_in, blank_in;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        swap_req;
  logic        swap_pending, frame_start;
  logic [5:0]  rgb;
  logic        hsync_out, vsync_out;

  baby_vga_pixel dut (
    .clk          (clk),
    .rst          (rst),
    .x_hi         (x_hi),
    .x_lo         (x_lo),
    .y_hi         (y_hi),
    .y_lo         (y_lo),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .blank_in     (blank_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .frame_start  (frame_start),
    .rgb          (rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];  // {rgb, hsync, vsync} per counter value, latency 2
  logic [1:0] st_q[$];   // {frame_start, swap_pending}, latency 1

  logic [31:0] m_fb [2][16];
  logic        m_sel, m_pend, m_vs_in;
  logic [5:0]  m_fg, m_bg;
  logic        prev_hs, prev_vs;

  logic [5:0]  r_xh;
  logic [4:0]  r_yh;
  logic        r_bl, r_hs, r_vs, r_we, r_sr;
  logic [4:0]  r_wa;
  logic [31:0] r_wd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 16; r++)
        m_fb[b][r] = 32'h0;
    m_sel   = 1'b0;
    m_pend  = 1'b0;
    m_vs_in = 1'b0;
    m_fg    = 6'h3F;
    m_bg    = 6'h00;
    prev_hs = 1'b1;
    prev_vs = 1'b0;
    exp_q.delete();
    st_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst      = 1'b1;
    x_hi     = 6'd0;
    x_lo     = 5'd0;
    y_hi     = 5'd0;
    y_lo     = 6'd0;
    blank_in = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'h0;
    swap_req = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rgb", {26'h0, rgb}, 32'h0);
    check_eq("rst_hsync", {31'h0, hsync_out}, 32'h1);
    check_eq("rst_vsync", {31'h0, vsync_out}, 32'h0);
    check_eq("rst_frame_start", {31'h0, frame_start}, 32'h0);
    check_eq("rst_swap_pending", {31'h0, swap_pending}, 32'h0);
    model_reset();
    rst = 1'b0;
  endtask

  // One pixel clock. hs/vs describe this counter value; the DUT sees them a cycle later.
  task automatic step(input logic [5:0] xh, input logic [4:0] xl, input logic [4:0] yh,
                      input logic [5:0] yl, input logic bl, input logic hs, input logic vs,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic sr);
    logic       bitv, rise;
    logic [5:0] e_rgb;
    logic [7:0] e;
    logic [1:0] s;
    x_hi     = xh;
    x_lo     = xl;
    y_hi     = yh;
    y_lo     = yl;
    blank_in = bl;
    hsync_in = prev_hs;
    vsync_in = prev_vs;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    swap_req = sr;

    bitv    = m_fb[m_sel][yh[3:0]][xh[4:0]];
    rise    = prev_vs && !m_vs_in;
    m_vs_in = prev_vs;
    if (we && wa == 5'd16) m_fg = wd[5:0];
    if (we && wa == 5'd17) m_bg = wd[5:0];
    e_rgb = bl ? 6'h00 : (bitv ? m_fg : m_bg);
    if (we && wa < 5'd16) m_fb[m_sel ^ DB][wa[3:0]] = wd;
    if (DB) begin
      if (rise && m_pend) begin
        m_sel  = !m_sel;
        m_pend = 1'b0;
      end else if (sr) begin
        m_pend = 1'b1;
      end
    end
    exp_q.push_back({e_rgb, hs, vs});
    st_q.push_back({rise, m_pend});
    prev_hs = hs;
    prev_vs = vs;

    @(posedge clk);
    @(negedge clk);
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      check_eq("frame_start", {31'h0, frame_start}, {31'h0, s[1]});
      check_eq("swap_pending", {31'h0, swap_pending}, {31'h0, s[0]});
    end
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check_eq("rgb", {26'h0, rgb}, {26'h0, e[7:2]});
      check_eq("hsync_out", {31'h0, hsync_out}, {31'h0, e[1]});
      check_eq("vsync_out", {31'h0, vsync_out}, {31'h0, e[0]});
    end
  endtask

  task automatic px(input logic [5:0] xh, input logic [4:0] yh, input logic bl);
    step(xh, 5'd0, yh, 6'd0, bl, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic pxv(input logic [5:0] xh, input logic [4:0] yh, input logic vs, input logic sr);
    step(xh, 5'd0, yh, 6'd0, 1'b0, 1'b1, vs, 1'b0, 5'd0, 32'h0, sr);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    step(6'd0, 5'd0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, wa, wd, 1'b0);
  endtask

  task automatic vpulse(input logic sr_on_edge);
    pxv(6'd0, 5'd0, 1'b1, 1'b0);
    pxv(6'd0, 5'd0, 1'b1, sr_on_edge);
    pxv(6'd0, 5'd0, 1'b1, 1'b0);
    repeat (3) pxv(6'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);

    repeat (3) px(6'd0, 5'd0, 1'b0);
    wr(5'd3, 32'h0000_0001);
    px(6'd0, 5'd3, 1'b0);
    px(6'd1, 5'd3, 1'b0);
    px(6'd0, 5'd3, 1'b0);

    wr(5'd16, 32'hFFFF_FF30);
    wr(5'd17, 32'h0000_000C);
    px(6'd0, 5'd3, 1'b0);
    px(6'd1, 5'd3, 1'b0);
    px(6'd0, 5'd3, 1'b1);
    px(6'd1, 5'd3, 1'b1);
    wr(5'd20, 32'hFFFF_FFFF);
    px(6'd0, 5'd3, 1'b0);
    px(6'd5, 5'd3, 1'b0);
    px(6'd40, 5'd20, 1'b1);
    px(6'd33, 5'd3, 1'b1);

    // Colour change lands mid-line, one cycle after the write.
    step(6'd0, 5'd0, 5'd3, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd16, 32'h0000_0015, 1'b0);
    px(6'd0, 5'd3, 1'b0);

    // One scan line with a 152-cycle hsync pulse.
    wr(5'd3, 32'hA5A5_0F0F);
    for (int h = 0; h < 800; h++)
      step(6'(h / 20), 5'(h % 20), 5'd3, 6'd0, (h >= 640), !(h >= 648), 1'b0,
           1'b0, 5'd0, 32'h0, 1'b0);

    // Back-bank row write, then swap at the next vsync rising edge.
    wr(5'd0, 32'hFFFF_FFFF);
    px(6'd0, 5'd0, 1'b0);
    px(6'd7, 5'd0, 1'b0);
    pxv(6'd0, 5'd0, 1'b0, 1'b1);
    pxv(6'd0, 5'd0, 1'b0, 1'b1);
    px(6'd0, 5'd0, 1'b0);
    vpulse(1'b0);
    px(6'd0, 5'd0, 1'b0);
    px(6'd31, 5'd0, 1'b0);

    // Request coinciding with the edge is held for the following frame.
    vpulse(1'b1);
    px(6'd0, 5'd0, 1'b0);
    px(6'd12, 5'd0, 1'b0);
    vpulse(1'b0);
    px(6'd0, 5'd0, 1'b0);
    px(6'd12, 5'd0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      r_xh = 6'($urandom_range(0, 39));
      r_yh = 5'($urandom_range(0, 20));
      r_bl = (r_xh >= 6'd32) || (r_yh >= 5'd16) || ($urandom_range(0, 3) == 0);
      r_hs = (i % 25) < 20;
      r_vs = (i % 50) >= 45;
      r_we = ($urandom_range(0, 3) == 0);
      r_wa = 5'($urandom_range(0, 31));
      r_wd = $urandom;
      r_sr = ($urandom_range(0, 15) == 0);
      step(r_xh, 5'($urandom_range(0, 19)), r_yh, 6'($urandom_range(0, 29)), r_bl,
           r_hs, r_vs, r_we, r_wa, r_wd, r_sr);
    end

    // Reset in the middle of activity.
    step(6'd2, 5'd0, 5'd1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
    do_reset(1);
    px(6'd0, 5'd3, 1'b0);
    px(6'd0, 5'd0, 1'b0);
    wr(5'd16, 32'h0000_0003);
    px(6'd0, 5'd3, 1'b0);
    px(6'd0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
